// File: rtl/decode_stage_hazard.sv
// decode_stage_hazard
//   RV32I decode stage sitting between fetch and execute. One instruction per
//   cycle is decoded into register indices, function fields and a
//   sign-extended immediate; operands are read through two combinational
//   register-file ports. A load in execute whose destination matches a used
//   source register causes a bubble (load-use hazard). A valid/ready handshake
//   on both sides holds the output bundle bit-stable under backpressure.
//   stall_count saturates at all-ones and counts hazard bubbles.
//
//   Optional build macro: DECODE_WB_BYPASS_EN
//     Adds wb_we / wb_rd / wb_data so a register being written back this cycle
//     is forwarded into the captured operand instead of the stale rf value.

module decode_stage_hazard #(
   parameter int XLEN        = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,

   // fetch side
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [XLEN-1:0]        in_pc,
   input  logic [31:0]            in_instr,
   input  logic                   flush,

   // register file read ports
   output logic [REG_ADDR_W-1:0]  rf_rs1_addr,
   output logic [REG_ADDR_W-1:0]  rf_rs2_addr,
   input  logic [XLEN-1:0]        rf_rs1_data,
   input  logic [XLEN-1:0]        rf_rs2_data,

   // execute stage status used for load-use detection
   input  logic                   ex_valid,
   input  logic                   ex_is_load,
   input  logic [REG_ADDR_W-1:0]  ex_rd,

`ifdef DECODE_WB_BYPASS_EN
   // write-back forwarding
   input  logic                   wb_we,
   input  logic [REG_ADDR_W-1:0]  wb_rd,
   input  logic [XLEN-1:0]        wb_data,
`endif

   // execute side
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_pc,
   output logic [6:0]             out_opcode,
   output logic [REG_ADDR_W-1:0]  out_rd,
   output logic [REG_ADDR_W-1:0]  out_rs1,
   output logic [REG_ADDR_W-1:0]  out_rs2,
   output logic [2:0]             out_funct3,
   output logic [6:0]             out_funct7,
   output logic [XLEN-1:0]        out_imm,
   output logic [XLEN-1:0]        out_rs1_value,
   output logic [XLEN-1:0]        out_rs2_value,
   output logic                   out_illegal,

   output logic [STALL_CNT_W-1:0] stall_count
);

   // ------------------------------------------------------------------
   // Opcodes and instruction formats
   // ------------------------------------------------------------------
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_NONE
   } fmt_e;

   // ------------------------------------------------------------------
   // Combinational decode of the incoming word
   // ------------------------------------------------------------------
   logic [6:0]            opcode;
   fmt_e                  fmt;
   logic                  use_rs1;
   logic                  use_rs2;
   logic                  use_rd;
   logic                  dec_illegal;
   logic [REG_ADDR_W-1:0] dec_rd;
   logic [REG_ADDR_W-1:0] dec_rs1;
   logic [REG_ADDR_W-1:0] dec_rs2;
   logic [2:0]            dec_funct3;
   logic [6:0]            dec_funct7;
   logic [31:0]           imm32;
   logic [XLEN-1:0]       dec_imm;
   logic [XLEN-1:0]       dec_rs1_value;
   logic [XLEN-1:0]       dec_rs2_value;

   assign opcode = in_instr[6:0];

   // Map opcode to instruction format; anything unrecognised is illegal.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      fmt         = FMT_NONE;
      dec_illegal = 1'b0;
      unique case (opcode)
         OPC_LUI, OPC_AUIPC:            fmt = FMT_U;
         OPC_JAL:                       fmt = FMT_J;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = FMT_I;
         OPC_BRANCH:                    fmt = FMT_B;
         OPC_STORE:                     fmt = FMT_S;
         OPC_OP:                        fmt = FMT_R;
         default:                       dec_illegal = 1'b1;
      endcase
   end

   // Register usage per format.
   assign use_rs1 = (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B) || (fmt == FMT_R);
   assign use_rs2 = (fmt == FMT_S) || (fmt == FMT_B) || (fmt == FMT_R);
   assign use_rd  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);

   // Unused index fields are forced to zero so downstream logic and the
   // register file see x0 for anything the format does not reference.
   assign dec_rd  = use_rd  ? REG_ADDR_W'(in_instr[11:7])  : '0;
   assign dec_rs1 = use_rs1 ? REG_ADDR_W'(in_instr[19:15]) : '0;
   assign dec_rs2 = use_rs2 ? REG_ADDR_W'(in_instr[24:20]) : '0;

   // funct3 only exists in I/S/B/R encodings; funct7 only in R.
   assign dec_funct3 = (use_rs1) ? in_instr[14:12] : 3'b000;
   assign dec_funct7 = (fmt == FMT_R) ? in_instr[31:25] : 7'b0000000;

   // Immediate assembly, 32 bits wide with the sign already in bit 31.
   always_comb begin
      imm32 = 32'h0;
      unique case (fmt)
         FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U:   imm32 = {in_instr[31:12], 12'h000};
         FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
         default: imm32 = 32'h0;
      endcase
   end

   // Sign-extend from instr[31] to the datapath width.
   assign dec_imm = XLEN'($signed(imm32));

   // Register file addressing follows the zeroed indices.
   assign rf_rs1_addr = dec_rs1;
   assign rf_rs2_addr = dec_rs2;

   // ------------------------------------------------------------------
   // Operand selection: x0 always reads zero, optionally forward write-back
   // ------------------------------------------------------------------
`ifdef DECODE_WB_BYPASS_EN
   logic byp_rs1;
   logic byp_rs2;

   assign byp_rs1 = wb_we && (wb_rd != '0) && (wb_rd == dec_rs1);
   assign byp_rs2 = wb_we && (wb_rd != '0) && (wb_rd == dec_rs2);

   assign dec_rs1_value = (dec_rs1 == '0) ? '0 : (byp_rs1 ? wb_data : rf_rs1_data);
   assign dec_rs2_value = (dec_rs2 == '0) ? '0 : (byp_rs2 ? wb_data : rf_rs2_data);
`else
   assign dec_rs1_value = (dec_rs1 == '0) ? '0 : rf_rs1_data;
   assign dec_rs2_value = (dec_rs2 == '0) ? '0 : rf_rs2_data;
`endif

   // ------------------------------------------------------------------
   // Handshake and load-use hazard
   // ------------------------------------------------------------------
   logic load;
   logic hazard;

   // The output register may take a new value when it is empty or drained.
   assign load = !out_valid || out_ready;

   assign hazard = in_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                   ((use_rs1 && (dec_rs1 == ex_rd)) ||
                    (use_rs2 && (dec_rs2 == ex_rd)));

   // A flush drops the incoming word, so it is always "accepted".
   assign in_ready = flush ? 1'b1 : (load && !hazard);

   // ------------------------------------------------------------------
   // Output bundle register with flush / bubble / capture priority
   // ------------------------------------------------------------------
   // Register the decoded bundle; hold everything when execute stalls.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         // NOTE: the whole bundle is reset, not just out_valid, so a
         // bundle held under backpressure never leaks out after reset.
         out_valid     <= 1'b0;
         out_pc        <= '0;
         out_opcode    <= '0;
         out_rd        <= '0;
         out_rs1       <= '0;
         out_rs2       <= '0;
         out_funct3    <= '0;
         out_funct7    <= '0;
         out_imm       <= '0;
         out_rs1_value <= '0;
         out_rs2_value <= '0;
         out_illegal   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         if (hazard) begin
            out_valid <= 1'b0;
         end else if (in_valid) begin
            out_valid     <= 1'b1;
            out_pc        <= in_pc;
            out_opcode    <= opcode;
            out_rd        <= dec_rd;
            out_rs1       <= dec_rs1;
            out_rs2       <= dec_rs2;
            out_funct3    <= dec_funct3;
            out_funct7    <= dec_funct7;
            out_imm       <= dec_imm;
            out_rs1_value <= dec_rs1_value;
            out_rs2_value <= dec_rs2_value;
            out_illegal   <= dec_illegal;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Hazard stall counter
   // ------------------------------------------------------------------
   // Count bubbles actually inserted; saturate rather than wrap. Flush does
   // not clear it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
      end else if (hazard && load && !flush && (stall_count != '1)) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_decode_stage_hazard.sv
// tb_decode_stage_hazard
//   Directed bench for decode_stage_hazard: a table of single-instruction
//   decode vectors followed by hand-written hazard, backpressure, flush,
//   saturation and reset sequences. A narrow stall counter keeps the
//   saturation sequence short.

module tb_decode_stage_hazard;

   localparam int XLEN        = 32;
   localparam int REG_ADDR_W  = 5;
   localparam int STALL_CNT_W = 3;

   logic                   clk;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [XLEN-1:0]        in_pc;
   logic [31:0]            in_instr;
   logic                   flush;
   logic [REG_ADDR_W-1:0]  rf_rs1_addr;
   logic [REG_ADDR_W-1:0]  rf_rs2_addr;
   logic [XLEN-1:0]        rf_rs1_data;
   logic [XLEN-1:0]        rf_rs2_data;
   logic                   ex_valid;
   logic                   ex_is_load;
   logic [REG_ADDR_W-1:0]  ex_rd;
`ifdef DECODE_WB_BYPASS_EN
   logic                   wb_we;
   logic [REG_ADDR_W-1:0]  wb_rd;
   logic [XLEN-1:0]        wb_data;
`endif
   logic                   out_valid;
   logic                   out_ready;
   logic [XLEN-1:0]        out_pc;
   logic [6:0]             out_opcode;
   logic [REG_ADDR_W-1:0]  out_rd;
   logic [REG_ADDR_W-1:0]  out_rs1;
   logic [REG_ADDR_W-1:0]  out_rs2;
   logic [2:0]             out_funct3;
   logic [6:0]             out_funct7;
   logic [XLEN-1:0]        out_imm;
   logic [XLEN-1:0]        out_rs1_value;
   logic [XLEN-1:0]        out_rs2_value;
   logic                   out_illegal;
   logic [STALL_CNT_W-1:0] stall_count;

   decode_stage_hazard #(
      .XLEN        (XLEN),
      .REG_ADDR_W  (REG_ADDR_W),
      .STALL_CNT_W (STALL_CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_pc         (in_pc),
      .in_instr      (in_instr),
      .flush         (flush),
      .rf_rs1_addr   (rf_rs1_addr),
      .rf_rs2_addr   (rf_rs2_addr),
      .rf_rs1_data   (rf_rs1_data),
      .rf_rs2_data   (rf_rs2_data),
      .ex_valid      (ex_valid),
      .ex_is_load    (ex_is_load),
      .ex_rd         (ex_rd),
`ifdef DECODE_WB_BYPASS_EN
      .wb_we         (wb_we),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
`endif
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_opcode    (out_opcode),
      .out_rd        (out_rd),
      .out_rs1       (out_rs1),
      .out_rs2       (out_rs2),
      .out_funct3    (out_funct3),
      .out_funct7    (out_funct7),
      .out_imm       (out_imm),
      .out_rs1_value (out_rs1_value),
      .out_rs2_value (out_rs2_value),
      .out_illegal   (out_illegal),
      .stall_count   (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string        nm;
      logic [31:0]  instr;
      logic [31:0]  rs1d;
      logic [31:0]  rs2d;
      logic [4:0]   rd;
      logic [4:0]   rs1;
      logic [4:0]   rs2;
      logic [2:0]   f3;
      logic [6:0]   f7;
      logic [31:0]  imm;
      logic         ill;
      logic [31:0]  v1;
      logic [31:0]  v2;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs[NVEC];

   localparam logic [31:0] ADD_X4_X3_X5 = 32'h0051_8233;
   localparam logic [31:0] LUI_X5       = 32'h1234_52B7;

   initial begin
      //            name     instr          rs1d          rs2d          rd  rs1 rs2 f3 f7     imm           ill v1            v2
      vecs[0]  = '{"addi",  32'hFFB10093, 32'h7,        32'h99,       1,  2,  0,  0, 7'h00, 32'hFFFFFFFB, 0,  32'h7,        32'h0};
      vecs[1]  = '{"beq",   32'hFE000EE3, 32'hDEADBEEF, 32'hDEADBEEF, 0,  0,  0,  0, 7'h00, 32'hFFFFFFFC, 0,  32'h0,        32'h0};
      vecs[2]  = '{"lui",   LUI_X5,       32'hDEADBEEF, 32'hDEADBEEF, 5,  0,  0,  0, 7'h00, 32'h12345000, 0,  32'h0,        32'h0};
      vecs[3]  = '{"add",   ADD_X4_X3_X5, 32'h30,       32'h50,       4,  3,  5,  0, 7'h00, 32'h0,        0,  32'h30,       32'h50};
      vecs[4]  = '{"sub",   32'h403100B3, 32'h10,       32'h3,        1,  2,  3,  0, 7'h20, 32'h0,        0,  32'h10,       32'h3};
      vecs[5]  = '{"sw",    32'hFE63AC23, 32'h100,      32'h200,      0,  7,  6,  2, 7'h00, 32'hFFFFFFF8, 0,  32'h100,      32'h200};
      vecs[6]  = '{"jal",   32'h001000EF, 32'hAA,       32'hBB,       1,  0,  0,  0, 7'h00, 32'h00000800, 0,  32'h0,        32'h0};
      vecs[7]  = '{"auipc", 32'h80000517, 32'hAA,       32'hBB,       10, 0,  0,  0, 7'h00, 32'h80000000, 0,  32'h0,        32'h0};
      vecs[8]  = '{"lw",    32'h7FF4A403, 32'h44,       32'h55,       8,  9,  0,  2, 7'h00, 32'h000007FF, 0,  32'h44,       32'h0};
      vecs[9]  = '{"jalr",  32'h00008067, 32'h123,      32'h5,        0,  1,  0,  0, 7'h00, 32'h0,        0,  32'h123,      32'h0};
      vecs[10] = '{"illeg", 32'h0000007F, 32'h1,        32'h2,        0,  0,  0,  0, 7'h00, 32'h0,        1,  32'h0,        32'h0};
   end

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_pc       = '0;
      in_instr    = '0;
      flush       = 1'b0;
      rf_rs1_data = '0;
      rf_rs2_data = '0;
      ex_valid    = 1'b0;
      ex_is_load  = 1'b0;
      ex_rd       = '0;
      out_ready   = 1'b1;
`ifdef DECODE_WB_BYPASS_EN
      wb_we       = 1'b0;
      wb_rd       = '0;
      wb_data     = '0;
`endif

      // ---------------- reset state ----------------
      tick();
      tick();
      check("rst.out_valid", out_valid, 0);
      check("rst.out_pc", out_pc, 0);
      check("rst.out_imm", out_imm, 0);
      check("rst.out_rd", out_rd, 0);
      check("rst.out_illegal", out_illegal, 0);
      check("rst.stall_count", stall_count, 0);
      rst = 1'b0;

      // ---------------- decode table ----------------
      for (int i = 0; i < NVEC; i++) begin
         in_valid    = 1'b1;
         in_instr    = vecs[i].instr;
         in_pc       = 32'h1000 + 32'(i * 4);
         rf_rs1_data = vecs[i].rs1d;
         rf_rs2_data = vecs[i].rs2d;
         #1;
         check({vecs[i].nm, ".in_ready"}, in_ready, 1);
         check({vecs[i].nm, ".rf_rs1_addr"}, rf_rs1_addr, vecs[i].rs1);
         check({vecs[i].nm, ".rf_rs2_addr"}, rf_rs2_addr, vecs[i].rs2);
         tick();
         check({vecs[i].nm, ".out_valid"}, out_valid, 1);
         check({vecs[i].nm, ".out_pc"}, out_pc, 32'h1000 + 32'(i * 4));
         check({vecs[i].nm, ".out_opcode"}, out_opcode, vecs[i].instr[6:0]);
         check({vecs[i].nm, ".out_rd"}, out_rd, vecs[i].rd);
         check({vecs[i].nm, ".out_rs1"}, out_rs1, vecs[i].rs1);
         check({vecs[i].nm, ".out_rs2"}, out_rs2, vecs[i].rs2);
         check({vecs[i].nm, ".out_funct3"}, out_funct3, vecs[i].f3);
         check({vecs[i].nm, ".out_funct7"}, out_funct7, vecs[i].f7);
         check({vecs[i].nm, ".out_imm"}, out_imm, vecs[i].imm);
         check({vecs[i].nm, ".out_illegal"}, out_illegal, vecs[i].ill);
         check({vecs[i].nm, ".out_rs1_value"}, out_rs1_value, vecs[i].v1);
         check({vecs[i].nm, ".out_rs2_value"}, out_rs2_value, vecs[i].v2);
      end

      // ---------------- load-use hazard on rs1 for two cycles ----------------
      in_valid    = 1'b1;
      in_instr    = ADD_X4_X3_X5;
      in_pc       = 32'h2000;
      rf_rs1_data = 32'h33;
      rf_rs2_data = 32'h55;
      ex_valid    = 1'b1;
      ex_is_load  = 1'b1;
      ex_rd       = 5'd3;
      for (int c = 0; c < 2; c++) begin
         #1;
         check("haz.in_ready", in_ready, 0);
         tick();
         check("haz.out_valid", out_valid, 0);
         check("haz.stall_count", stall_count, 3'(c + 1));
      end
      ex_valid = 1'b0;
      #1;
      check("haz_release.in_ready", in_ready, 1);
      tick();
      check("haz_release.out_valid", out_valid, 1);
      check("haz_release.out_rd", out_rd, 4);
      check("haz_release.out_rs1_value", out_rs1_value, 32'h33);
      check("haz_release.stall_count", stall_count, 2);

      // Load to x0 never stalls.
      ex_valid = 1'b1;
      ex_rd    = 5'd0;
      #1;
      check("haz_x0.in_ready", in_ready, 1);
      tick();
      check("haz_x0.out_valid", out_valid, 1);
      check("haz_x0.stall_count", stall_count, 2);
      ex_valid = 1'b0;

      // ---------------- backpressure: hold bundle for 3 cycles ----------------
      out_ready = 1'b0;
      in_instr  = LUI_X5;
      in_pc     = 32'h3000;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("bp.in_ready", in_ready, 0);
         tick();
         check("bp.out_valid", out_valid, 1);
         check("bp.out_rd", out_rd, 4);
         check("bp.out_pc", out_pc, 32'h2000);
         check("bp.out_imm", out_imm, 0);
         check("bp.stall_count", stall_count, 2);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release.in_ready", in_ready, 1);
      tick();
      check("bp_release.out_rd", out_rd, 5);
      check("bp_release.out_imm", out_imm, 32'h12345000);
      check("bp_release.out_pc", out_pc, 32'h3000);

      // ---------------- flush while stalled ----------------
      in_instr   = ADD_X4_X3_X5;
      ex_valid   = 1'b1;
      ex_is_load = 1'b1;
      ex_rd      = 5'd3;
      flush      = 1'b1;
      #1;
      check("flush.in_ready", in_ready, 1);
      tick();
      check("flush.out_valid", out_valid, 0);
      check("flush.stall_count", stall_count, 2);
      flush    = 1'b0;
      ex_valid = 1'b0;
      in_instr = 32'h0000_007F;
      tick();
      check("post_flush.out_valid", out_valid, 1);
      check("post_flush.out_illegal", out_illegal, 1);
      check("post_flush.out_imm", out_imm, 0);

      // ---------------- stall counter saturation (rs2 match) ----------------
      in_instr = ADD_X4_X3_X5;
      ex_valid = 1'b1;
      ex_rd    = 5'd5;
      #1;
      check("sat.in_ready", in_ready, 0);
      for (int c = 0; c < 8; c++) tick();
      check("sat.stall_count", stall_count, 3'b111);
      check("sat.out_valid", out_valid, 0);
      ex_valid = 1'b0;

      // ---------------- reset during backpressure ----------------
      in_instr = LUI_X5;
      tick();
      check("rbp.out_valid_before", out_valid, 1);
      out_ready = 1'b0;
      rst       = 1'b1;
      tick();
      check("rbp.out_valid", out_valid, 0);
      check("rbp.out_rd", out_rd, 0);
      check("rbp.out_imm", out_imm, 0);
      check("rbp.stall_count", stall_count, 0);
      rst       = 1'b0;
      out_ready = 1'b1;

`ifdef DECODE_WB_BYPASS_EN
      // ---------------- write-back bypass ----------------
      in_instr    = 32'h0001_0093;   // addi x1,x2,0
      rf_rs1_data = 32'h11;
      wb_we       = 1'b1;
      wb_rd       = 5'd2;
      wb_data     = 32'h55;
      tick();
      check("byp.out_rs1_value", out_rs1_value, 32'h55);
      wb_rd = 5'd0;
      tick();
      check("byp_x0.out_rs1_value", out_rs1_value, 32'h11);
      wb_rd = 5'd2;
      wb_we = 1'b0;
      tick();
      check("byp_off.out_rs1_value", out_rs1_value, 32'h11);
`endif

      in_valid = 1'b0;
      tick();
      check("idle.out_valid", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage_hazard.md
Name: decode_stage_hazard

Overview:
Parametrised decode pipeline stage between fetch and execute. Every cycle it does the following:
- Decodes one RV32I instruction.
- Generates the sign-extended immediate for all formats (I/S/B/U/J).
- Drives two register-file read ports.
- Detects load-use hazards against the execute stage and inserts bubbles.
It uses a full valid/ready handshake that holds state under backpressure, supports a flush input, and keeps a stall-cycle counter.

Parameters:
XLEN, 32, datapath width for pc, immediate and register values
REG_ADDR_W, 5, register index width
STALL_CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch word valid
in_ready  out  1  decode accepts fetch word this cycle
in_pc  in  XLEN  instruction address
in_instr  in  32  raw instruction
flush  in  1  discard in-flight and incoming instruction
rf_rs1_addr  out  REG_ADDR_W  read port 1 address
rf_rs2_addr  out  REG_ADDR_W  read port 2 address
rf_rs1_data  in  XLEN  read port 1 data, combinational same cycle
rf_rs2_data  in  XLEN  read port 2 data, combinational same cycle
ex_valid  in  1  execute stage holds valid instruction
ex_is_load  in  1  execute instruction is a load
ex_rd  in  REG_ADDR_W  execute destination register
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  XLEN  registered pc
out_opcode  out  7  opcode
out_rd, out_rs1, out_rs2  out  REG_ADDR_W each  register indices; 0 when the format does not use them
out_funct3  out  3  funct3
out_funct7  out  7  funct7; 0 unless R-type
out_imm  out  XLEN  sign-extended immediate; 0 for R-type or illegal
out_rs1_value, out_rs2_value  out  XLEN  operand values
out_illegal  out  1  opcode not in the supported set
stall_count  out  STALL_CNT_W  saturating count of hazard stall cycles

Behaviour:
- Supported opcodes and formats:
  - LUI 0110111 (U), AUIPC 0010111 (U), JAL 1101111 (J)
  - JALR 1100111 (I), LOAD 0000011 (I), OP-IMM 0010011 (I)
  - BRANCH 1100011 (B), STORE 0100011 (S), OP 0110011 (R)
  - Any other opcode sets out_illegal=1 with rd/rs1/rs2/imm all 0.
- Register usage:
  - rs1 used by I/S/B/R.
  - rs2 used by S/B/R.
  - rd written by R/I/U/J.
  - Unused fields are forced to 0, and rf addresses for unused sources are 0.
- Immediates:
  - B and J immediates have bit 0 = 0.
  - U immediate is instr[31:12]<<12.
  - All immediates are sign-extended from instr[31] to XLEN.
- x0 reads: an operand value is 0 whenever its source index is 0, regardless of rf data.
- Output register load enable: load = !out_valid || out_ready.
- Hazard: in_valid && ex_valid && ex_is_load && ex_rd!=0 && ((rs1 used && rs1==ex_rd) || (rs2 used && rs2==ex_rd)).
- in_ready = load && !hazard, or 1 when flush=1.
- Per cycle, priority highest first:
  1. flush: out_valid<=0 and the incoming word is dropped.
  2. load && hazard: out_valid<=0 (bubble) and the input is not consumed.
  3. load && in_valid: capture the decoded bundle and set out_valid<=1.
  4. load && !in_valid: out_valid<=0.
  5. !load: all outputs hold, bit-stable.
- Latency: 1 cycle from in_valid&&in_ready to out_valid.
- stall_count increments on each cycle with hazard && load && !flush and saturates at all-ones; it is not cleared by flush.
- Reset: out_valid=0, every data output=0, stall_count=0. Reset during backpressure discards the held bundle.

Optional Feature:
Macro: DECODE_WB_BYPASS_EN
- Enabled:
  - Adds ports wb_we (in, 1), wb_rd (in, REG_ADDR_W) and wb_data (in, XLEN).
  - An operand whose index is nonzero and equals wb_rd while wb_we=1 takes wb_data instead of rf data at capture.
  - The x0 rule still wins.
- Disabled: these ports are absent and operands come only from rf data.

Test Plan:
- addi x1,x2,-5 (0xFFB10093), rf_rs1_data=7, out_ready=1 -> next cycle: out_rd=1, out_rs1=2, out_imm=0xFFFFFFFB, out_rs1_value=7, out_rs2=0, out_illegal=0.
- beq x0,x0,-4 (0xFE000EE3) -> out_imm=0xFFFFFFFC, both operand values 0 despite rf data 0xDEADBEEF. Then lui x5,0x12345 (0x123452B7) -> out_imm=0x12345000, out_rs1=0.
- ex_valid=1, ex_is_load=1, ex_rd=3 for 2 cycles while in_instr=add x4,x3,x5:
  - in_ready=0 for 2 cycles, out_valid=0, stall_count=2.
  - After ex_valid drops, the add issues. The same case with ex_rd=0 gives no stall.
- out_ready=0 for 3 cycles with a valid bundle held -> outputs unchanged, in_ready=0, stall_count unchanged. out_ready=1 -> next instruction captured the following cycle.
- flush=1 while stalled on a hazard -> in_ready=1, out_valid=0 next cycle, stall_count not incremented. Instruction word 0x0000007F -> out_illegal=1, out_imm=0.
- With DECODE_WB_BYPASS_EN: wb_we=1, wb_rd=2, wb_data=0x55, rf data=0x11 on addi x1,x2,0 -> out_rs1_value=0x55. wb_rd=0 has no effect.
